// File: rtl/univ_bin_counter_seq_if.sv
// -----------------------------------------------------------------------------
// univ_bin_counter_seq_if
//   Command channel between a host and univ_bin_counter_seq.
//   The host drives the command; the sequencer drives cmd_ready.
//
//   cmd_valid  host -> seq  a command is present on cmd_op/cmd_arg/cmd_len
//   cmd_ready  seq  -> host sequencer accepts a command this cycle
//   cmd_op     host -> seq  opcode (0 NOP .. 7 UP_TO_ARG)
//   cmd_arg    host -> seq  load value, or target value for UP_TO_ARG
//   cmd_len    host -> seq  number of enabled count cycles for UP/DOWN
// -----------------------------------------------------------------------------
interface univ_bin_counter_seq_if #(
    parameter int N  = 3,
    parameter int CW = 8
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_op;
    logic [N-1:0]  cmd_arg;
    logic [CW-1:0] cmd_len;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_arg,
        output cmd_len,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_arg,
        input  cmd_len,
        output cmd_ready
    );
endinterface

// File: rtl/univ_bin_counter_seq.sv
// -----------------------------------------------------------------------------
// univ_bin_counter_seq
//   Command-driven sequencer for one univ_bin_counter. Accepts one command at
//   a time, drives the counter's control pins, watches q/max_tick/min_tick to
//   decide when the command is finished and emits a one-cycle done pulse.
//
//   clk            rising-edge clock
//   reset          synchronous, active-high reset
//   cmd            command channel (slave side): valid/ready/op/arg/len
//   abort          terminates a running count (ignored outside RUN)
//   busy           a command is in progress
//   done           one-cycle completion pulse
//   aborted        last command ended by abort; held until next accept
//   cnt_syn_clear  to counter syn_clear
//   cnt_load       to counter load
//   cnt_en         to counter en
//   cnt_up         to counter up
//   cnt_d          to counter d
//   cnt_q          from counter q
//   cnt_max_tick   from counter max_tick
//   cnt_min_tick   from counter min_tick
// -----------------------------------------------------------------------------
module univ_bin_counter_seq #(
    parameter int N  = 3,
    parameter int CW = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    univ_bin_counter_seq_if.slave        cmd,
    input  logic                         abort,
    output logic                         busy,
    output logic                         done,
    output logic                         aborted,
    output logic                         cnt_syn_clear,
    output logic                         cnt_load,
    output logic                         cnt_en,
    output logic                         cnt_up,
    output logic [N-1:0]                 cnt_d,
    input  logic [N-1:0]                 cnt_q,
    input  logic                         cnt_max_tick,
    input  logic                         cnt_min_tick
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_RUN,
        S_DONE
    } state_t;

    typedef enum logic [2:0] {
        OP_NOP         = 3'd0,
        OP_CLEAR       = 3'd1,
        OP_LOAD        = 3'd2,
        OP_UP          = 3'd3,
        OP_DOWN        = 3'd4,
        OP_UP_TO_MAX   = 3'd5,
        OP_DOWN_TO_MIN = 3'd6,
        OP_UP_TO_ARG   = 3'd7
    } op_t;

    state_t        r_state;
    state_t        w_state_nxt;
    op_t           r_op;
    logic [N-1:0]  r_d;
    logic          r_up;
    logic [CW-1:0] r_rem;
    logic          r_aborted;

    logic          w_accept;
    logic          w_stop;
    logic          w_en;
    logic          w_clr;
    logic          w_ld;
    logic          w_ready;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and counter controls
    always_comb begin
        w_state_nxt = r_state;
        w_stop      = 1'b1;
        w_en        = 1'b0;
        w_clr       = 1'b0;
        w_ld        = 1'b0;
        w_ready     = (r_state == S_IDLE) && !reset;
        w_accept    = cmd.cmd_valid && w_ready;

        // The counter's q and ticks are registered, so deciding the stop in
        // the same cycle that gates en is free of combinational loops.
        case (r_op)
            OP_UP, OP_DOWN:  w_stop = (r_rem == '0);
            OP_UP_TO_MAX:    w_stop = cnt_max_tick;
            OP_DOWN_TO_MIN:  w_stop = cnt_min_tick;
            OP_UP_TO_ARG:    w_stop = (cnt_q == r_d);
            default:         w_stop = 1'b1;
        endcase

        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    case (op_t'(cmd.cmd_op))
                        OP_NOP:            w_state_nxt = S_DONE;
                        OP_CLEAR, OP_LOAD: w_state_nxt = S_EXEC;
                        default:           w_state_nxt = S_RUN;
                    endcase
                end
            end
            S_EXEC: begin
                w_clr       = (r_op == OP_CLEAR);
                w_ld        = (r_op == OP_LOAD);
                w_state_nxt = S_DONE;
            end
            S_RUN: begin
                w_en = !w_stop && !abort;
                if (w_stop || abort) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (reset) begin
            w_en  = 1'b0;
            w_clr = 1'b0;
            w_ld  = 1'b0;
        end
    end

    // Command registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_op      <= OP_NOP;
            r_d       <= '0;
            r_up      <= 1'b1;
            r_rem     <= '0;
            r_aborted <= 1'b0;
        end else if (w_accept) begin
            r_op      <= op_t'(cmd.cmd_op);
            r_d       <= cmd.cmd_arg;
            r_rem     <= cmd.cmd_len;
            r_aborted <= 1'b0;
            case (op_t'(cmd.cmd_op))
                OP_UP, OP_UP_TO_MAX, OP_UP_TO_ARG: r_up <= 1'b1;
                OP_DOWN, OP_DOWN_TO_MIN:           r_up <= 1'b0;
                default:                           r_up <= r_up;
            endcase
        end else if (r_state == S_RUN) begin
            if (w_en && (r_op == OP_UP || r_op == OP_DOWN)) begin
                r_rem <= r_rem - CW'(1);
            end
            // A stop reached in the same cycle takes precedence over abort.
            if (abort && !w_stop) begin
                r_aborted <= 1'b1;
            end
        end
    end

    assign cmd.cmd_ready   = w_ready;
    assign busy            = (r_state != S_IDLE);
    assign done            = (r_state == S_DONE);
    assign aborted         = r_aborted;
    assign cnt_syn_clear   = w_clr;
    assign cnt_load        = w_ld;
    assign cnt_en          = w_en;
    assign cnt_up          = r_up;
    assign cnt_d           = r_d;

endmodule

// File: tb/tb_univ_bin_counter_seq.sv
module tb_univ_bin_counter_seq;

    localparam int N    = 3;
    localparam int CW   = 8;
    localparam int MAXV = (1 << N) - 1;

    logic          clk;
    logic          reset;
    logic          abort;
    logic          busy;
    logic          done;
    logic          aborted;
    logic          cnt_syn_clear;
    logic          cnt_load;
    logic          cnt_en;
    logic          cnt_up;
    logic [N-1:0]  cnt_d;
    logic [N-1:0]  q;
    logic          max_tick;
    logic          min_tick;

    int n_chk  = 0;
    int n_fail = 0;
    int m_q    = 0;

    univ_bin_counter_seq_if #(.N(N), .CW(CW)) cmd_if ();

    univ_bin_counter_seq #(.N(N), .CW(CW)) dut (
        .clk           (clk),
        .reset         (reset),
        .cmd           (cmd_if.slave),
        .abort         (abort),
        .busy          (busy),
        .done          (done),
        .aborted       (aborted),
        .cnt_syn_clear (cnt_syn_clear),
        .cnt_load      (cnt_load),
        .cnt_en        (cnt_en),
        .cnt_up        (cnt_up),
        .cnt_d         (cnt_d),
        .cnt_q         (q),
        .cnt_max_tick  (max_tick),
        .cnt_min_tick  (min_tick)
    );

    // Environment: the universal binary counter being sequenced.
    always @(posedge clk) begin
        if (reset)              q <= '0;
        else if (cnt_syn_clear) q <= '0;
        else if (cnt_load)      q <= cnt_d;
        else if (cnt_en)        q <= cnt_up ? q + 1'b1 : q - 1'b1;
    end
    assign max_tick = (q == '1);
    assign min_tick = (q == '0);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, required end of test");
        $fatal(1);
    end

    typedef struct {
        int lat;
        int en;
        int ups;
        int ld;
        int clr;
        int dload;
        int q;
        int ab;
        int multi;
        int nbusy;
        int ready_after;
    } res_t;

    // Reference: outcome of one command from the starting counter value.
    function automatic res_t model(int op, int arg, int len, int q0, int abort_at);
        res_t e;
        int   nat;
        bit   run;
        bit   up;
        e   = '{default: 0};
        run = (op >= 3);
        up  = (op == 3) || (op == 5) || (op == 7);
        case (op)
            3, 4:    nat = len;
            5:       nat = MAXV - q0;
            6:       nat = q0;
            7:       nat = (arg - q0) & MAXV;
            default: nat = 0;
        endcase
        e.en  = nat;
        e.lat = (op == 0) ? 1 : (op <= 2) ? 2 : nat + 2;
        if (run && abort_at >= 1 && abort_at <= nat) begin
            e.en  = abort_at - 1;
            e.ab  = 1;
            e.lat = abort_at + 1;
        end
        e.ups = up ? e.en : 0;
        if (op == 1)      e.q = 0;
        else if (op == 2) e.q = arg;
        else if (run)     e.q = (up ? q0 + e.en : q0 - e.en) & MAXV;
        else              e.q = q0;
        e.ld          = (op == 2) ? 1 : 0;
        e.clr         = (op == 1) ? 1 : 0;
        e.dload       = (op == 2) ? arg : 0;
        e.ready_after = 1;
        return e;
    endfunction

    // Issue one command and record what the sequencer did until done.
    task automatic run_cmd(input int op, input int arg, input int len,
                           input int abort_at, output res_t r);
        int waits;
        r = '{default: 0};
        @(negedge clk);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = 3'(op);
        cmd_if.cmd_arg   = N'(arg);
        cmd_if.cmd_len   = CW'(len);
        waits = 0;
        while (!cmd_if.cmd_ready && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        if (!cmd_if.cmd_ready) begin
            cmd_if.cmd_valid = 1'b0;
            r.lat = -1;
            return;
        end
        @(posedge clk);
        #1 cmd_if.cmd_valid = 1'b0;
        for (int j = 1; j <= 300; j++) begin
            @(negedge clk);
            abort = (j == abort_at);
            #1;
            if (cnt_en) begin
                r.en++;
                if (cnt_up) r.ups++;
            end
            if (cnt_load) begin
                r.ld++;
                r.dload = int'(cnt_d);
            end
            if (cnt_syn_clear) r.clr++;
            if (int'(cnt_en) + int'(cnt_load) + int'(cnt_syn_clear) > 1) r.multi++;
            if (!busy) r.nbusy++;
            if (done) begin
                r.lat = j;
                r.ab  = int'(aborted);
                break;
            end
        end
        abort = 1'b0;
        @(negedge clk);
        #1;
        r.ready_after = (cmd_if.cmd_ready && !done) ? 1 : 0;
        r.q = int'(q);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        abort = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op    = '0;
        cmd_if.cmd_arg   = '0;
        cmd_if.cmd_len   = '0;
        repeat (2) @(negedge clk);
        #1;
        n_chk++;
        if (cmd_if.cmd_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_ready: got %b expected 0", cmd_if.cmd_ready);
        end
        n_chk++;
        if ({cnt_en, cnt_load, cnt_syn_clear} !== 3'b000) begin
            n_fail++; $display("FAIL reset_ctl: got en/ld/clr=%b expected 000", {cnt_en, cnt_load, cnt_syn_clear});
        end
        n_chk++;
        if ({busy, done, aborted} !== 3'b000) begin
            n_fail++; $display("FAIL reset_status: got busy/done/aborted=%b expected 000", {busy, done, aborted});
        end
        n_chk++;
        if (cnt_d !== '0 || cnt_up !== 1'b1) begin
            n_fail++; $display("FAIL reset_dup: got d=%0d up=%b expected d=0 up=1", cnt_d, cnt_up);
        end
        reset = 1'b0;
        m_q = 0;
        #1;
        n_chk++;
        if (cmd_if.cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL post_reset_ready: got %b expected 1", cmd_if.cmd_ready);
        end
    endtask

    task automatic test_load_clear();
        int ops [5] = '{2, 2, 1, 0, 2};
        int args[5] = '{3, 5, 0, 0, 1};
        int abt [5] = '{0, 0, 0, 0, 1};
        res_t r, e;
        for (int i = 0; i < 5; i++) begin
            e = model(ops[i], args[i], 0, m_q, abt[i]);
            run_cmd(ops[i], args[i], 0, abt[i], r);
            m_q = e.q;
            n_chk++;
            if (r.lat !== e.lat) begin
                n_fail++; $display("FAIL ldclr_latency[%0d]: got %0d expected %0d", i, r.lat, e.lat);
            end
            n_chk++;
            if (r.ld !== e.ld || r.clr !== e.clr || r.dload !== e.dload || r.en !== 0) begin
                n_fail++; $display("FAIL ldclr_pulses[%0d]: got ld=%0d clr=%0d d=%0d en=%0d expected ld=%0d clr=%0d d=%0d en=0",
                                   i, r.ld, r.clr, r.dload, r.en, e.ld, e.clr, e.dload);
            end
            n_chk++;
            if (r.q !== e.q || r.ab !== e.ab) begin
                n_fail++; $display("FAIL ldclr_result[%0d]: got q=%0d ab=%0d expected q=%0d ab=%0d", i, r.q, r.ab, e.q, e.ab);
            end
            n_chk++;
            if (r.multi !== 0 || r.nbusy !== 0 || r.ready_after !== 1) begin
                n_fail++; $display("FAIL ldclr_protocol[%0d]: got multi=%0d nbusy=%0d ready=%0d expected 0 0 1",
                                   i, r.multi, r.nbusy, r.ready_after);
            end
        end
    endtask

    // ops: list of {op, arg, len, abort_at} run and checked in order
    task automatic test_counting(input string nm, input int n, input int tab[8][4]);
        res_t r, e;
        for (int i = 0; i < n; i++) begin
            e = model(tab[i][0], tab[i][1], tab[i][2], m_q, tab[i][3]);
            run_cmd(tab[i][0], tab[i][1], tab[i][2], tab[i][3], r);
            m_q = e.q;
            n_chk++;
            if (r.lat !== e.lat) begin
                n_fail++; $display("FAIL %s_latency[%0d]: got %0d expected %0d", nm, i, r.lat, e.lat);
            end
            n_chk++;
            if (r.en !== e.en || r.ups !== e.ups) begin
                n_fail++; $display("FAIL %s_enables[%0d]: got en=%0d up=%0d expected en=%0d up=%0d", nm, i, r.en, r.ups, e.en, e.ups);
            end
            n_chk++;
            if (r.q !== e.q) begin
                n_fail++; $display("FAIL %s_q[%0d]: got %0d expected %0d", nm, i, r.q, e.q);
            end
            n_chk++;
            if (r.ab !== e.ab) begin
                n_fail++; $display("FAIL %s_aborted[%0d]: got %0d expected %0d", nm, i, r.ab, e.ab);
            end
            n_chk++;
            if (r.ld !== e.ld || r.clr !== e.clr || r.multi !== 0 || r.nbusy !== 0 || r.ready_after !== 1) begin
                n_fail++; $display("FAIL %s_protocol[%0d]: got ld=%0d clr=%0d multi=%0d nbusy=%0d ready=%0d expected %0d %0d 0 0 1",
                                   nm, i, r.ld, r.clr, r.multi, r.nbusy, r.ready_after, e.ld, e.clr);
            end
        end
    endtask

    task automatic test_len_counts();
        int tab[8][4] = '{'{1,0,0,0}, '{3,0,10,0}, '{4,0,3,0}, '{3,0,0,0},
                          '{4,0,9,0}, '{0,0,0,0}, '{0,0,0,0}, '{0,0,0,0}};
        test_counting("len", 5, tab);
    endtask

    task automatic test_targets();
        int tab[8][4] = '{'{2,2,0,0}, '{5,0,0,0}, '{5,0,0,0}, '{6,0,0,0},
                          '{6,0,0,0}, '{2,6,0,0}, '{7,2,0,0}, '{7,2,0,0}};
        test_counting("tgt", 8, tab);
    endtask

    task automatic test_abort();
        int tab[8][4] = '{'{1,0,0,0}, '{3,0,20,5}, '{4,0,6,1}, '{2,1,0,0},
                          '{5,0,0,3}, '{6,0,0,2}, '{7,5,0,4}, '{3,0,2,4}};
        test_counting("abort", 8, tab);
    endtask

    task automatic test_random();
        int   tab[8][4];
        int   qs;
        res_t e0;
        for (int blk = 0; blk < 5; blk++) begin
            qs = m_q;
            for (int i = 0; i < 8; i++) begin
                tab[i][0] = int'($urandom_range(0, 7));
                tab[i][1] = int'($urandom_range(0, MAXV));
                tab[i][2] = int'($urandom_range(0, 12));
                tab[i][3] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 15)) : 0;
                e0 = model(tab[i][0], tab[i][1], tab[i][2], qs, 0);
                // Abort coinciding with the natural stop is left ambiguous.
                if (tab[i][0] >= 3 && tab[i][3] == e0.en + 1) tab[i][3] = 0;
                qs = model(tab[i][0], tab[i][1], tab[i][2], qs, tab[i][3]).q;
            end
            test_counting("rand", 8, tab);
        end
    endtask

    task automatic test_reset_midrun();
        int   waits;
        bit   saw_done;
        @(negedge clk);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = 3'd3;
        cmd_if.cmd_len   = CW'(50);
        waits = 0;
        while (!cmd_if.cmd_ready && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        @(posedge clk);
        #1 cmd_if.cmd_valid = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        n_chk++;
        if (cnt_en !== 1'b1) begin
            n_fail++; $display("FAIL midrun_en: got %b expected 1", cnt_en);
        end
        reset = 1'b1;
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = 3'd2;
        cmd_if.cmd_arg   = N'(5);
        #1;
        n_chk++;
        if (cnt_en !== 1'b0 || cmd_if.cmd_ready !== 1'b0) begin
            n_fail++; $display("FAIL midrun_reset_cycle: got en=%b ready=%b expected 0 0", cnt_en, cmd_if.cmd_ready);
        end
        saw_done = 1'b0;
        repeat (2) begin
            @(negedge clk);
            #1;
            saw_done |= done;
        end
        n_chk++;
        if (busy !== 1'b0 || cmd_if.cmd_ready !== 1'b0 || saw_done !== 1'b0) begin
            n_fail++; $display("FAIL midrun_idle: got busy=%b ready=%b done_seen=%b expected 0 0 0",
                               busy, cmd_if.cmd_ready, saw_done);
        end
        reset = 1'b0;
        m_q = 0;
        #1;
        n_chk++;
        if (cmd_if.cmd_ready !== 1'b1 || int'(q) !== m_q) begin
            n_fail++; $display("FAIL midrun_release: got ready=%b q=%0d expected 1 %0d", cmd_if.cmd_ready, q, m_q);
        end
        @(posedge clk);
        #1 cmd_if.cmd_valid = 1'b0;
        waits = 0;
        for (int j = 1; j <= 20; j++) begin
            @(negedge clk);
            #1;
            if (done) begin
                waits = j;
                break;
            end
        end
        @(negedge clk);
        #1;
        m_q = 5;
        n_chk++;
        if (waits !== 2 || int'(q) !== m_q) begin
            n_fail++; $display("FAIL held_valid_load: got latency=%0d q=%0d expected 2 %0d", waits, q, m_q);
        end
    endtask

    initial begin
        test_reset();
        test_load_clear();
        test_len_counts();
        test_targets();
        test_abort();
        test_reset_midrun();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/univ_bin_counter_seq.md
Name: univ_bin_counter_seq

Overview:
- Command-driven sequencer for one `univ_bin_counter` instance.
- Accepts one command at a time over a valid/ready handshake and turns it into the counter's control signals: `syn_clear`, `load`, `en`, `up`, `d`.
- Watches the counter's `q`, `max_tick` and `min_tick` to decide when a command has finished, then reports completion.
- Sits between a host/test FSM and the counter so callers never drive counter pins cycle-by-cycle.

Parameters:
- N, 3, counter width; must match the counter's N.
- CW, 8, width of the step-count field `cmd_len`.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  a command is present on the cmd_* inputs.
- cmd_ready  out  1  sequencer can accept a command this cycle.
- cmd_op  in  3  opcode (see Behaviour).
- cmd_arg  in  N  load value, or target value for UP_TO_ARG.
- cmd_len  in  CW  number of enabled count cycles for UP/DOWN.
- abort  in  1  terminates a running count.
- busy  out  1  a command is in progress.
- done  out  1  one-cycle completion pulse.
- aborted  out  1  last command ended by abort; valid while done=1, held until next accept.
- cnt_syn_clear  out  1  to counter `syn_clear`.
- cnt_load  out  1  to counter `load`.
- cnt_en  out  1  to counter `en`.
- cnt_up  out  1  to counter `up`.
- cnt_d  out  N  to counter `d`.
- cnt_q  in  N  from counter `q`.
- cnt_max_tick  in  1  from counter `max_tick`.
- cnt_min_tick  in  1  from counter `min_tick`.

Behaviour:
- **Opcodes:**
  - 0 NOP
  - 1 CLEAR
  - 2 LOAD
  - 3 UP(len)
  - 4 DOWN(len)
  - 5 UP_TO_MAX
  - 6 DOWN_TO_MIN
  - 7 UP_TO_ARG
- **States:** IDLE, EXEC, RUN, DONE.
- **Reset** (synchronous, when reset=1 at the edge):
  - state=IDLE; busy=0, done=0, aborted=0, cnt_d=0, cnt_up=1, internal remaining count=0.
  - While reset=1: cmd_ready=0; cnt_syn_clear, cnt_load and cnt_en are forced to 0 combinationally.
  - Reset mid-command abandons the command; no done pulse is generated.
- **Handshake:**
  - cmd_ready = (state==IDLE) && !reset.
  - A command is accepted on an edge where cmd_valid && cmd_ready.
  - On accept, register: op, cmd_arg into cnt_d, cmd_len into remaining; clear aborted.
  - cmd_* inputs are ignored while cmd_ready=0.
- **IDLE:**
  - On accept, go to EXEC for CLEAR/LOAD, to DONE for NOP, otherwise to RUN.
  - cnt_up is set on accept: 1 for UP/UP_TO_MAX/UP_TO_ARG, 0 for DOWN/DOWN_TO_MIN; it holds its last value otherwise.
- **EXEC** (exactly one cycle):
  - cnt_syn_clear=1 (CLEAR) or cnt_load=1 (LOAD, with cnt_d=arg).
  - Counter updates at the edge ending EXEC; next state DONE.
- **RUN:**
  - stop is combinational from registered state and counter inputs:
    - UP/DOWN: remaining==0.
    - UP_TO_MAX: cnt_max_tick.
    - DOWN_TO_MIN: cnt_min_tick.
    - UP_TO_ARG: cnt_q==cnt_d.
  - cnt_en = (state==RUN) && !stop && !abort. Combinational use of cnt_q is legal because the counter's q is registered.
  - UP/DOWN decrement remaining on each enabled cycle.
  - Go to DONE when stop or abort; if abort was the cause, set aborted=1.
  - A target already met on entry gives zero enabled cycles (e.g. len=0, or UP_TO_MAX with q=max).
  - Counter wrap-around is not a stop condition for UP/DOWN, e.g. UP len=10 with N=3 wraps.
- **abort** has no effect outside RUN.
- **DONE** (one cycle): done=1, then IDLE.
- **busy** = state!=IDLE.
- cnt_syn_clear and cnt_load are never both 1, and neither is ever 1 together with cnt_en.
- **Latency from accept edge to done high:**
  - CLEAR/LOAD: 2 cycles.
  - NOP: 1 cycle.
  - UP/DOWN with len L: L+2 cycles.
  - Back-to-back commands: next accept at the earliest on the edge after done.

Test Plan:
- Reset 2 cycles, then LOAD arg=3 → one cycle of cnt_load=1 with cnt_d=3; q=3; done pulses 2 cycles after accept; cmd_ready returns 1 the next cycle.
- CLEAR with q=5 → one cycle of cnt_syn_clear=1; q=0; cnt_en never asserted.
- From q=0, UP len=10 → exactly 10 enabled cycles; q sequence 1..7,0,1,2; done at accept+12; cnt_up=1 throughout. Follow with DOWN len=3 → q=7 (1, 0, 7).
- From q=2, UP_TO_MAX → q goes 3..7, cnt_en drops the cycle max_tick=1, done pulses. Then UP_TO_MAX again → zero enables, done at accept+2. Then DOWN_TO_MIN → q reaches 0 with min_tick=1.
- From q=6, UP_TO_ARG arg=2 → wraps 7, 0, 1, 2 and stops (4 enables). Separately, UP len=20 with abort asserted on the 5th RUN cycle → exactly 4 enables, done with aborted=1.
- Assert reset during RUN of UP len=50 → cnt_en=0 in the reset cycle; IDLE afterwards with no done pulse; cmd_valid held high during reset is not accepted until reset=0.
